// File: rtl/rtc_pkg.sv
// Shared field widths, range limits, alarm record and month-length helper for the RTC core.
// February gains a leap day only when RTC_LEAP_YEAR_EN is defined.
package rtc_pkg;

  localparam int SEC_W  = 6;
  localparam int MIN_W  = 6;
  localparam int HOUR_W = 5;
  localparam int DAY_W  = 5;
  localparam int MON_W  = 4;
  localparam int YEAR_W = 7;

  localparam logic [SEC_W-1:0]  SEC_MAX  = 6'd59;
  localparam logic [MIN_W-1:0]  MIN_MAX  = 6'd59;
  localparam logic [HOUR_W-1:0] HOUR_MAX = 5'd23;
  localparam logic [MON_W-1:0]  MON_MAX  = 4'd12;
  localparam logic [YEAR_W-1:0] YEAR_MAX = 7'd99;

`ifdef RTC_LEAP_YEAR_EN
  localparam bit LEAP_EN = 1'b1;
`else
  localparam bit LEAP_EN = 1'b0;
`endif

  typedef struct packed {
    logic              en;
    logic [HOUR_W-1:0] hour;
    logic [MIN_W-1:0]  min;
  } alarm_t;

  typedef enum logic [1:0] {
    LD_RESET = 2'd0,
    LD_READY = 2'd1,
    LD_HOLD  = 2'd2
  } load_state_t;

  // Years 2000..2099: divisible by four is exactly the leap rule, so two bits suffice.
  function automatic logic [DAY_W-1:0] month_len(input logic [MON_W-1:0] month,
                                                   input logic [1:0]       year_lo);
    logic [DAY_W-1:0] len;
    case (month)
      4'd4, 4'd6, 4'd9, 4'd11: len = 5'd30;
      4'd2:                    len = (LEAP_EN && (year_lo == 2'b00)) ? 5'd29 : 5'd28;
      default:                 len = 5'd31;
    endcase
    return len;
  endfunction

endpackage

// File: rtl/rtc_calendar_core_if.sv
// Load handshake and alarm-programming bus of the RTC core.
// valid/ready: a load transfers on any rising clk edge where set_valid && set_ready; the master holds its fields stable while set_valid is high.
interface rtc_calendar_core_if #(
  parameter int NUM_ALARMS = 2
);
  import rtc_pkg::*;

  localparam int AW = (NUM_ALARMS > 1) ? $clog2(NUM_ALARMS) : 1;

  logic                  set_valid;
  logic                  set_ready;
  logic [SEC_W-1:0]      set_sec;
  logic [MIN_W-1:0]      set_min;
  logic [HOUR_W-1:0]     set_hour;
  logic [DAY_W-1:0]      set_day;
  logic [MON_W-1:0]      set_month;
  logic [YEAR_W-1:0]     set_year;
  logic                  set_err;

  logic                  alarm_wr;
  logic [AW-1:0]         alarm_idx;
  logic [HOUR_W-1:0]     alarm_hour;
  logic [MIN_W-1:0]      alarm_min;
  logic                  alarm_en;
  logic [NUM_ALARMS-1:0] alarm_ack;
  logic [NUM_ALARMS-1:0] alarm_fire;

  modport master (
    output set_valid, set_sec, set_min, set_hour, set_day, set_month, set_year,
    output alarm_wr, alarm_idx, alarm_hour, alarm_min, alarm_en, alarm_ack,
    input  set_ready, set_err, alarm_fire
  );

  modport slave (
    input  set_valid, set_sec, set_min, set_hour, set_day, set_month, set_year,
    input  alarm_wr, alarm_idx, alarm_hour, alarm_min, alarm_en, alarm_ack,
    output set_ready, set_err, alarm_fire
  );

endinterface

// File: rtl/rtc_prescaler.sv
// Divides the system clock down to one wrap pulse per second; a clear restarts the count at zero.
module rtc_prescaler #(
  parameter int CLK_HZ = 100000000
) (
  input  logic clk,
  input  logic rst,
  input  logic i_enable,
  input  logic i_clear,
  output logic o_wrap
);

  localparam int CW = $clog2(CLK_HZ);
  localparam logic [CW-1:0] TERM = CW'(CLK_HZ - 1);

  logic [CW-1:0] r_cnt;
  logic          w_at_term;

  assign w_at_term = (r_cnt == TERM);
  assign o_wrap    = i_enable && w_at_term;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (i_clear) begin
      r_cnt <= '0;
    end else if (i_enable) begin
      r_cnt <= w_at_term ? '0 : r_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/rtc_calendar_core.sv
// Real-time clock/calendar with atomic load, manual day/month stepping and hh:mm alarm channels.
// Build option: RTC_LEAP_YEAR_EN enables the February leap day.
module rtc_calendar_core
  import rtc_pkg::*;
#(
  parameter int CLK_HZ     = 100000000,
  parameter int NUM_ALARMS = 2
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                enable,
  rtc_calendar_core_if.slave  bus,
  input  logic                inc_day,
  input  logic                inc_month,
  output logic                tick_1hz,
  output logic [SEC_W-1:0]    seconds,
  output logic [MIN_W-1:0]    minutes,
  output logic [HOUR_W-1:0]   hours,
  output logic [DAY_W-1:0]    day,
  output logic [MON_W-1:0]    month,
  output logic [YEAR_W-1:0]   year,
  output load_state_t         o_dbg_state
);

  logic [SEC_W-1:0]      r_sec;
  logic [MIN_W-1:0]      r_min;
  logic [HOUR_W-1:0]     r_hour;
  logic [DAY_W-1:0]      r_day;
  logic [MON_W-1:0]      r_month;
  logic [YEAR_W-1:0]     r_year;
  logic                  r_tick;
  logic                  r_set_err;
  logic                  r_pend_day;
  logic                  r_pend_mon;
  logic [NUM_ALARMS-1:0] r_fire;
  alarm_t                r_alarm [NUM_ALARMS];
  load_state_t           r_ld_state;
  load_state_t           w_ld_next;

  logic                  w_set_ready;
  logic                  w_wrap;
  logic                  w_load_hs;
  logic                  w_set_ok;
  logic                  w_load_ok;
  logic                  w_tick_adv;
  logic                  w_busy;
  logic                  w_do_inc_day;
  logic                  w_do_inc_mon;
  logic [SEC_W-1:0]      w_nsec;
  logic [MIN_W-1:0]      w_nmin;
  logic [HOUR_W-1:0]     w_nhour;
  logic [DAY_W-1:0]      w_nday;
  logic [MON_W-1:0]      w_nmon;
  logic [YEAR_W-1:0]     w_nyear;
  logic [MON_W-1:0]      w_imon;
  logic [DAY_W-1:0]      w_ilen;
  logic [DAY_W-1:0]      w_iday;
  logic [NUM_ALARMS-1:0] w_fire_set;

  rtc_prescaler #(.CLK_HZ(CLK_HZ)) u_prescaler (
    .clk      (clk),
    .rst      (reset),
    .i_enable (enable),
    .i_clear  (w_load_ok),
    .o_wrap   (w_wrap)
  );

  // Load FSM: ready in LD_READY only, so every accepted or rejected load costs one dead cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_ld_state <= LD_RESET;
    else       r_ld_state <= w_ld_next;
  end

  always_comb begin
    w_ld_next   = r_ld_state;
    w_set_ready = 1'b0;
    case (r_ld_state)
      LD_RESET: w_ld_next = LD_READY;
      LD_READY: begin
        w_set_ready = 1'b1;
        if (bus.set_valid) w_ld_next = LD_HOLD;
      end
      LD_HOLD:  w_ld_next = LD_READY;
      default:  w_ld_next = LD_READY;
    endcase
  end

  assign w_load_hs = bus.set_valid && w_set_ready;
  assign w_set_ok  = (bus.set_sec <= SEC_MAX) && (bus.set_min <= MIN_MAX) &&
                     (bus.set_hour <= HOUR_MAX) && (bus.set_year <= YEAR_MAX) &&
                     (bus.set_month != '0) && (bus.set_month <= MON_MAX) &&
                     (bus.set_day != '0) &&
                     (bus.set_day <= month_len(bus.set_month, bus.set_year[1:0]));
  assign w_load_ok  = w_load_hs && w_set_ok;
  assign w_tick_adv = w_wrap && !w_load_ok;
  assign w_busy     = w_load_hs || w_wrap;

  assign w_do_inc_day = !w_busy && (inc_day || r_pend_day);
  assign w_do_inc_mon = !w_busy && (inc_month || r_pend_mon);

  always_comb begin
    w_nsec  = r_sec;
    w_nmin  = r_min;
    w_nhour = r_hour;
    w_nday  = r_day;
    w_nmon  = r_month;
    w_nyear = r_year;
    if (r_sec < SEC_MAX) begin
      w_nsec = r_sec + 1'b1;
    end else begin
      w_nsec = '0;
      if (r_min < MIN_MAX) begin
        w_nmin = r_min + 1'b1;
      end else begin
        w_nmin = '0;
        if (r_hour < HOUR_MAX) begin
          w_nhour = r_hour + 1'b1;
        end else begin
          w_nhour = '0;
          if (r_day < month_len(r_month, r_year[1:0])) begin
            w_nday = r_day + 1'b1;
          end else begin
            w_nday = 5'd1;
            if (r_month < MON_MAX) begin
              w_nmon = r_month + 1'b1;
            end else begin
              w_nmon  = 4'd1;
              w_nyear = (r_year < YEAR_MAX) ? r_year + 1'b1 : '0;
            end
          end
        end
      end
    end
  end

  // Month steps first so a day step wraps against the new month's length.
  always_comb begin
    w_imon = r_month;
    if (w_do_inc_mon) w_imon = (r_month >= MON_MAX) ? 4'd1 : r_month + 1'b1;
    w_ilen = month_len(w_imon, r_year[1:0]);
    w_iday = (r_day > w_ilen) ? w_ilen : r_day;
    if (w_do_inc_day) w_iday = (w_iday >= w_ilen) ? 5'd1 : w_iday + 1'b1;
  end

  always_comb begin
    w_fire_set = '0;
    for (int n = 0; n < NUM_ALARMS; n++) begin
      w_fire_set[n] = w_tick_adv && r_alarm[n].en && (w_nsec == '0) &&
                      (w_nmin == r_alarm[n].min) && (w_nhour == r_alarm[n].hour);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sec      <= '0;
      r_min      <= '0;
      r_hour     <= '0;
      r_day      <= 5'd1;
      r_month    <= 4'd1;
      r_year     <= '0;
      r_tick     <= 1'b0;
      r_set_err  <= 1'b0;
      r_pend_day <= 1'b0;
      r_pend_mon <= 1'b0;
      r_fire     <= '0;
    end else begin
      r_tick    <= w_tick_adv;
      r_set_err <= w_load_hs && !w_set_ok;
      r_fire    <= (r_fire & ~bus.alarm_ack) | w_fire_set;
      if (w_load_ok) begin
        r_sec   <= bus.set_sec;
        r_min   <= bus.set_min;
        r_hour  <= bus.set_hour;
        r_day   <= bus.set_day;
        r_month <= bus.set_month;
        r_year  <= bus.set_year;
      end else if (w_tick_adv) begin
        r_sec   <= w_nsec;
        r_min   <= w_nmin;
        r_hour  <= w_nhour;
        r_day   <= w_nday;
        r_month <= w_nmon;
        r_year  <= w_nyear;
      end else begin
        r_day   <= w_iday;
        r_month <= w_imon;
      end
      if (w_busy) begin
        r_pend_day <= r_pend_day | inc_day;
        r_pend_mon <= r_pend_mon | inc_month;
      end else begin
        r_pend_day <= 1'b0;
        r_pend_mon <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int n = 0; n < NUM_ALARMS; n++) r_alarm[n] <= '0;
    end else if (bus.alarm_wr && (int'(bus.alarm_idx) < NUM_ALARMS)) begin
      r_alarm[bus.alarm_idx] <= '{en: bus.alarm_en, hour: bus.alarm_hour, min: bus.alarm_min};
    end
  end

  assign bus.set_ready  = w_set_ready;
  assign bus.set_err    = r_set_err;
  assign bus.alarm_fire = r_fire;
  assign tick_1hz       = r_tick;
  assign seconds        = r_sec;
  assign minutes        = r_min;
  assign hours          = r_hour;
  assign day            = r_day;
  assign month          = r_month;
  assign year           = r_year;
  assign o_dbg_state    = r_ld_state;

endmodule

// File: tb/tb_rtc_calendar_core.sv
// Self-checking bench for rtc_calendar_core with CLK_HZ=4 so a second lasts four clocks.
// Expectations follow RTC_LEAP_YEAR_EN when it is defined for the build.
module tb_rtc_calendar_core;
  import rtc_pkg::*;

  localparam int CLK_HZ     = 4;
  localparam int NUM_ALARMS = 2;
  localparam int AW         = 1;
`ifdef RTC_LEAP_YEAR_EN
  localparam bit LEAP = 1'b1;
`else
  localparam bit LEAP = 1'b0;
`endif

  logic        clk;
  logic        reset;
  logic        enable;
  logic        inc_day;
  logic        inc_month;
  logic        tick_1hz;
  logic [5:0]  seconds;
  logic [5:0]  minutes;
  logic [4:0]  hours;
  logic [4:0]  day;
  logic [3:0]  month;
  logic [6:0]  year;
  load_state_t dbg_state;

  rtc_calendar_core_if #(.NUM_ALARMS(NUM_ALARMS)) bus ();

  rtc_calendar_core #(.CLK_HZ(CLK_HZ), .NUM_ALARMS(NUM_ALARMS)) dut (
    .clk         (clk),
    .reset       (reset),
    .enable      (enable),
    .bus         (bus),
    .inc_day     (inc_day),
    .inc_month   (inc_month),
    .tick_1hz    (tick_1hz),
    .seconds     (seconds),
    .minutes     (minutes),
    .hours       (hours),
    .day         (day),
    .month       (month),
    .year        (year),
    .o_dbg_state (dbg_state)
  );

  // Clock / watchdog
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout required finish");
    $fatal(1, "watchdog");
  end

  // Scoreboard: {set_err, hh, mm, ss, dd, mo, yy}
  logic [33:0] exp_q[$];
  int total = 0;
  int bad   = 0;

  typedef struct packed {
    logic        exp_err;
    logic [32:0] t;
  } load_vec_t;

  load_vec_t vecs[13];

  function automatic logic [32:0] tv(input int h, input int m, input int s,
                                     input int d, input int mo, input int y);
    return {5'(h), 6'(m), 6'(s), 5'(d), 4'(mo), 7'(y)};
  endfunction

  function automatic logic [32:0] dut_time();
    return {hours, minutes, seconds, day, month, year};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic sb_check(input string name);
    logic [33:0] e;
    total++;
    if (exp_q.size() == 0) begin
      bad++;
      $display("FAIL %s: got empty expected queue required entry", name);
    end else begin
      total--;
      e = exp_q.pop_front();
      check({name, "_err"}, 64'(bus.set_err), 64'(e[33]));
      check({name, "_time"}, 64'(dut_time()), 64'(e[32:0]));
    end
  endtask

  task automatic do_load(input logic [32:0] t);
    int n;
    n = 0;
    while (bus.set_ready !== 1'b1 && n < 10) begin
      cyc();
      n++;
    end
    check("ready_before_load", 64'(bus.set_ready), 64'(1));
    {bus.set_hour, bus.set_min, bus.set_sec, bus.set_day, bus.set_month, bus.set_year} = t;
    bus.set_valid = 1'b1;
    cyc();
    bus.set_valid = 1'b0;
  endtask

  task automatic load_and_check(input string name, input logic [32:0] t);
    do_load(t);
    sb_check(name);
    check({name, "_ready_drop"}, 64'(bus.set_ready), 64'(0));
    cyc();
    check({name, "_ready_back"}, 64'(bus.set_ready), 64'(1));
    check({name, "_err_clear"}, 64'(bus.set_err), 64'(0));
  endtask

  task automatic tick_and_check(input string name, input int exp_cycles);
    int c;
    c = 0;
    do begin
      cyc();
      c++;
    end while (tick_1hz !== 1'b1 && c < 20);
    check({name, "_tick"}, 64'(tick_1hz), 64'(1));
    check({name, "_spacing"}, 64'(c), 64'(exp_cycles));
    sb_check(name);
  endtask

  task automatic pulse_inc(input logic d, input logic m);
    inc_day   = d;
    inc_month = m;
    cyc();
    inc_day   = 1'b0;
    inc_month = 1'b0;
  endtask

  task automatic write_alarm(input logic [AW-1:0] idx, input int h, input int m, input logic en);
    bus.alarm_idx  = idx;
    bus.alarm_hour = 5'(h);
    bus.alarm_min  = 6'(m);
    bus.alarm_en   = en;
    bus.alarm_wr   = 1'b1;
    cyc();
    bus.alarm_wr   = 1'b0;
  endtask

  initial begin
    logic [32:0] last_good;

    // Reset
    reset = 1'b1;
    enable = 1'b0;
    inc_day = 1'b0;
    inc_month = 1'b0;
    bus.set_valid = 1'b0;
    {bus.set_hour, bus.set_min, bus.set_sec, bus.set_day, bus.set_month, bus.set_year} = '0;
    bus.alarm_wr = 1'b0;
    bus.alarm_idx = '0;
    bus.alarm_hour = '0;
    bus.alarm_min = '0;
    bus.alarm_en = 1'b0;
    bus.alarm_ack = '0;
    #3;
    check("rst_time", 64'(dut_time()), 64'(tv(0, 0, 0, 1, 1, 0)));
    check("rst_tick", 64'(tick_1hz), 64'(0));
    check("rst_err", 64'(bus.set_err), 64'(0));
    check("rst_fire", 64'(bus.alarm_fire), 64'(0));
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    cyc();
    check("ready_after_rst", 64'(bus.set_ready), 64'(1));

    // Table-driven loads with time frozen
    vecs[0]  = {1'b0, tv(12, 34, 56, 15, 6, 21)};
    vecs[1]  = {1'b1, tv(10, 0, 0, 31, 4, 21)};
    vecs[2]  = {1'b0, tv(10, 0, 0, 30, 4, 21)};
    vecs[3]  = {1'b1, tv(10, 0, 60, 1, 1, 21)};
    vecs[4]  = {1'b1, tv(24, 0, 0, 1, 1, 21)};
    vecs[5]  = {1'b1, tv(1, 2, 3, 1, 13, 21)};
    vecs[6]  = {1'b1, tv(1, 2, 3, 1, 0, 21)};
    vecs[7]  = {1'b1, tv(1, 2, 3, 0, 5, 21)};
    vecs[8]  = {!LEAP, tv(5, 6, 7, 29, 2, 24)};
    vecs[9]  = {1'b1, tv(5, 6, 7, 29, 2, 23)};
    vecs[10] = {1'b0, tv(8, 9, 10, 28, 2, 23)};
    vecs[11] = {1'b1, tv(8, 9, 10, 1, 1, 100)};
    vecs[12] = {1'b0, tv(23, 59, 59, 31, 12, 99)};
    last_good = tv(0, 0, 0, 1, 1, 0);
    for (int i = 0; i < 13; i++) begin
      if (vecs[i].exp_err) begin
        exp_q.push_back({1'b1, last_good});
      end else begin
        exp_q.push_back({1'b0, vecs[i].t});
        last_good = vecs[i].t;
      end
      load_and_check($sformatf("vec%0d", i), vecs[i].t);
    end

    // Ticks and full rollover; first tick comes 3 cycles after the ready_back sample
    enable = 1'b1;
    exp_q.push_back({1'b0, tv(23, 59, 58, 31, 12, 99)});
    load_and_check("ld_roll", tv(23, 59, 58, 31, 12, 99));
    exp_q.push_back({1'b0, tv(23, 59, 59, 31, 12, 99)});
    tick_and_check("roll_t1", 3);
    exp_q.push_back({1'b0, tv(0, 0, 0, 1, 1, 0)});
    tick_and_check("roll_t2", 4);

    // February end, leap and common year; load restarts the prescaler
    exp_q.push_back({1'b0, tv(23, 59, 59, 28, 2, 24)});
    load_and_check("ld_feb24", tv(23, 59, 59, 28, 2, 24));
    exp_q.push_back({1'b0, LEAP ? tv(0, 0, 0, 29, 2, 24) : tv(0, 0, 0, 1, 3, 24)});
    tick_and_check("feb24", 3);
    exp_q.push_back({1'b0, tv(23, 59, 59, 28, 2, 23)});
    load_and_check("ld_feb23", tv(23, 59, 59, 28, 2, 23));
    exp_q.push_back({1'b0, tv(0, 0, 0, 1, 3, 23)});
    tick_and_check("feb23", 3);

    // Manual increments with time frozen
    enable = 1'b0;
    exp_q.push_back({1'b0, tv(10, 20, 30, 31, 1, 24)});
    load_and_check("ld_jan31", tv(10, 20, 30, 31, 1, 24));
    pulse_inc(1'b0, 1'b1);
    exp_q.push_back({1'b0, LEAP ? tv(10, 20, 30, 29, 2, 24) : tv(10, 20, 30, 28, 2, 24)});
    sb_check("inc_mon_clamp");
    pulse_inc(1'b1, 1'b0);
    exp_q.push_back({1'b0, tv(10, 20, 30, 1, 2, 24)});
    sb_check("inc_day_feb_wrap");
    exp_q.push_back({1'b0, tv(10, 20, 30, 31, 3, 24)});
    load_and_check("ld_mar31", tv(10, 20, 30, 31, 3, 24));
    pulse_inc(1'b1, 1'b0);
    exp_q.push_back({1'b0, tv(10, 20, 30, 1, 3, 24)});
    sb_check("inc_day_wrap");
    exp_q.push_back({1'b0, tv(1, 1, 1, 15, 12, 99)});
    load_and_check("ld_dec15", tv(1, 1, 1, 15, 12, 99));
    pulse_inc(1'b0, 1'b1);
    exp_q.push_back({1'b0, tv(1, 1, 1, 15, 1, 99)});
    sb_check("inc_mon_wrap");

    // Alarms
    enable = 1'b1;
    write_alarm(1'b0, 7, 30, 1'b1);
    write_alarm(1'b1, 7, 30, 1'b0);
    repeat ($urandom_range(0, 3)) cyc();
    exp_q.push_back({1'b0, tv(7, 29, 58, 15, 1, 99)});
    load_and_check("ld_alarm", tv(7, 29, 58, 15, 1, 99));
    check("fire_after_load", 64'(bus.alarm_fire), 64'(0));
    exp_q.push_back({1'b0, tv(7, 29, 59, 15, 1, 99)});
    tick_and_check("al_t1", 3);
    check("fire_t1", 64'(bus.alarm_fire), 64'(0));
    exp_q.push_back({1'b0, tv(7, 30, 0, 15, 1, 99)});
    tick_and_check("al_t2", 4);
    check("fire_t2", 64'(bus.alarm_fire), 64'(2'b01));
    write_alarm(1'b0, 7, 30, 1'b0);
    check("fire_kept_on_disable", 64'(bus.alarm_fire), 64'(2'b01));
    write_alarm(1'b0, 7, 30, 1'b1);
    exp_q.push_back({1'b0, tv(7, 29, 59, 15, 1, 99)});
    load_and_check("ld_alarm2", tv(7, 29, 59, 15, 1, 99));
    check("fire_kept_on_load", 64'(bus.alarm_fire), 64'(2'b01));
    cyc();
    cyc();
    bus.alarm_ack = 2'b01;
    cyc();
    bus.alarm_ack = 2'b00;
    check("ack_fire_tick", 64'(tick_1hz), 64'(1));
    exp_q.push_back({1'b0, tv(7, 30, 0, 15, 1, 99)});
    sb_check("ack_fire_time");
    check("set_beats_ack", 64'(bus.alarm_fire), 64'(2'b01));
    bus.alarm_ack = 2'b01;
    cyc();
    bus.alarm_ack = 2'b00;
    check("ack_clears", 64'(bus.alarm_fire), 64'(0));
    exp_q.push_back({1'b0, tv(7, 30, 0, 15, 1, 99)});
    load_and_check("ld_on_alarm", tv(7, 30, 0, 15, 1, 99));
    check("load_no_fire", 64'(bus.alarm_fire), 64'(0));

    // inc_day landing on the wrap edge is deferred one cycle
    exp_q.push_back({1'b0, tv(10, 0, 0, 10, 5, 24)});
    load_and_check("ld_pend", tv(10, 0, 0, 10, 5, 24));
    cyc();
    cyc();
    inc_day = 1'b1;
    cyc();
    inc_day = 1'b0;
    check("pend_tick", 64'(tick_1hz), 64'(1));
    exp_q.push_back({1'b0, tv(10, 0, 1, 10, 5, 24)});
    sb_check("pend_hold");
    cyc();
    exp_q.push_back({1'b0, tv(10, 0, 1, 11, 5, 24)});
    sb_check("pend_apply");

    // Asynchronous reset mid-count
    cyc();
    #2;
    reset = 1'b1;
    #1;
    check("async_rst_time", 64'(dut_time()), 64'(tv(0, 0, 0, 1, 1, 0)));
    check("async_rst_tick", 64'(tick_1hz), 64'(0));
    check("async_rst_fire", 64'(bus.alarm_fire), 64'(0));
    @(negedge clk);
    reset = 1'b0;
    cyc();
    check("ready_after_rst2", 64'(bus.set_ready), 64'(1));
    exp_q.push_back({1'b0, tv(0, 0, 1, 1, 1, 0)});
    tick_and_check("post_rst", 3);

    check("queue_drained", 64'(exp_q.size()), 64'(0));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
